// File: rtl/multi_issue_result_collector_pkg.sv
// Shared constants and helpers for the multi-issue result collector.
package multi_issue_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_SKID       = 2;

    // Width of a lane index; a single lane still gets one bit.
    function automatic int lane_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_issue_result_collector_if.sv
// Result-side and writeback-side signals of the collector.
interface multi_issue_result_collector_if
    import multi_issue_pkg::*;
#(
    parameter int  ISSUE_WIDTH = 4,
    parameter int  XLEN        = 32,
    parameter type hartid_t    = logic,
    parameter type id_t        = logic
) ();
    localparam int LANE_W = lane_idx_width(ISSUE_WIDTH);

    logic    [ISSUE_WIDTH-1:0]           result_valid_i;
    logic    [ISSUE_WIDTH-1:0][XLEN-1:0] result_i;
    logic    [ISSUE_WIDTH-1:0]           result_we_i;
    logic    [ISSUE_WIDTH-1:0][4:0]      result_rd_addr_i;
    hartid_t [ISSUE_WIDTH-1:0]           result_hartid_i;
    id_t     [ISSUE_WIDTH-1:0]           result_id_i;
    logic    [ISSUE_WIDTH-1:0]           result_overflow_i;
    logic    [ISSUE_WIDTH-1:0]           lane_ready_o;

    logic                                wb_valid_o;
    logic                                wb_ready_i;
    logic    [XLEN-1:0]                  wb_data_o;
    logic                                wb_we_o;
    logic    [4:0]                       wb_rd_addr_o;
    hartid_t                             wb_hartid_o;
    id_t                                 wb_id_o;
    logic                                wb_overflow_o;
    logic    [LANE_W-1:0]                wb_lane_o;

    logic    [ISSUE_WIDTH-1:0]           drop_o;
    logic                                err_o;
    logic                                idle_o;

    modport slave (
        input  result_valid_i, result_i, result_we_i, result_rd_addr_i,
               result_hartid_i, result_id_i, result_overflow_i, wb_ready_i,
        output lane_ready_o, wb_valid_o, wb_data_o, wb_we_o, wb_rd_addr_o,
               wb_hartid_o, wb_id_o, wb_overflow_o, wb_lane_o,
               drop_o, err_o, idle_o
    );

    modport master (
        output result_valid_i, result_i, result_we_i, result_rd_addr_i,
               result_hartid_i, result_id_i, result_overflow_i, wb_ready_i,
        input  lane_ready_o, wb_valid_o, wb_data_o, wb_we_o, wb_rd_addr_o,
               wb_hartid_o, wb_id_o, wb_overflow_o, wb_lane_o,
               drop_o, err_o, idle_o
    );

endinterface

// File: rtl/multi_issue_result_collector_fifo.sv
// Per-lane result FIFO with combinational head read and a registered
// issue-ready flag derived from the post-edge occupancy.
module result_lane_fifo #(
    parameter int  DEPTH   = 4,
    parameter int  SKID    = 2,
    parameter type entry_t = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  entry_t                     wdata_i,
    output entry_t                     rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       ready_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg, count_next;
    logic            ready_reg;
    logic            do_push, do_pop;

    assign full_o  = (count_reg == CW'(DEPTH));
    assign empty_o = (count_reg == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO only takes a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + CW'(1);
        else if (!do_push && do_pop)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
            ready_reg <= (DEPTH - int'(count_next)) >= SKID;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_reg] <= wdata_i;
    end

    assign rdata_o = mem[rd_ptr_reg];
    assign count_o = count_reg;
    assign ready_o = ready_reg;

endmodule

// File: rtl/multi_issue_result_collector.sv
// Collects per-lane execution results into lane FIFOs and serialises them
// onto a single writeback port with round-robin arbitration.
module multi_issue_result_collector
    import multi_issue_pkg::*;
#(
    parameter int  ISSUE_WIDTH = 4,
    parameter int  XLEN        = 32,
    parameter int  FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int  SKID        = DEFAULT_SKID,
    parameter type hartid_t    = logic,
    parameter type id_t        = logic
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    multi_issue_result_collector_if.slave bus
);
    localparam int LANE_W = lane_idx_width(ISSUE_WIDTH);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            we;
        logic [4:0]      rd_addr;
        hartid_t         hartid;
        id_t             id;
        logic            overflow;
    } entry_t;

    entry_t                   lane_wdata [ISSUE_WIDTH];
    entry_t                   lane_rdata [ISSUE_WIDTH];
    logic [CW-1:0]            lane_count [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0]   lane_full, lane_empty, lane_ready, lane_pop;
    logic [ISSUE_WIDTH-1:0]   drop_next, drop_reg;

    logic                     wb_valid_reg;
    entry_t                   wb_entry_reg;
    logic [LANE_W-1:0]        wb_lane_reg, last_grant_reg, grant_idx, cand_idx;
    logic                     grant_valid, load, err_reg, any_busy;

    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_lane
        assign lane_wdata[gi] = '{
            data:     bus.result_i[gi],
            we:       bus.result_we_i[gi],
            rd_addr:  bus.result_rd_addr_i[gi],
            hartid:   bus.result_hartid_i[gi],
            id:       bus.result_id_i[gi],
            overflow: bus.result_overflow_i[gi]
        };
        assign drop_next[gi] = bus.result_valid_i[gi] && lane_full[gi] && !lane_pop[gi];

        result_lane_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .SKID    (SKID),
            .entry_t (entry_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (bus.result_valid_i[gi]),
            .pop_i   (lane_pop[gi]),
            .wdata_i (lane_wdata[gi]),
            .rdata_o (lane_rdata[gi]),
            .full_o  (lane_full[gi]),
            .empty_o (lane_empty[gi]),
            .count_o (lane_count[gi]),
            .ready_o (lane_ready[gi])
        );
    end

    // Round-robin search begins one past the most recent grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_grant_reg;
        cand_idx    = '0;
        for (int off = 1; off <= ISSUE_WIDTH; off++) begin
            cand_idx = LANE_W'((int'(last_grant_reg) + off) % ISSUE_WIDTH);
            if (!grant_valid && !lane_empty[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign load = (!wb_valid_reg || bus.wb_ready_i) && grant_valid;

    always_comb begin
        lane_pop = '0;
        if (load) lane_pop[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_reg   <= 1'b0;
            wb_entry_reg   <= '0;
            wb_lane_reg    <= '0;
            last_grant_reg <= LANE_W'(ISSUE_WIDTH - 1);
            drop_reg       <= '0;
            err_reg        <= 1'b0;
        end else begin
            if (load) begin
                wb_valid_reg   <= 1'b1;
                wb_entry_reg   <= lane_rdata[grant_idx];
                wb_lane_reg    <= grant_idx;
                last_grant_reg <= grant_idx;
            end else if (bus.wb_ready_i) begin
                wb_valid_reg <= 1'b0;
            end
            drop_reg <= drop_next;
            err_reg  <= err_reg || (|drop_next);
        end
    end

    always_comb begin
        any_busy = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++)
            any_busy = any_busy || (lane_count[i] != '0);
    end

    assign bus.lane_ready_o  = lane_ready;
    assign bus.wb_valid_o    = wb_valid_reg;
    assign bus.wb_data_o     = wb_entry_reg.data;
    assign bus.wb_we_o       = wb_entry_reg.we;
    assign bus.wb_rd_addr_o  = wb_entry_reg.rd_addr;
    assign bus.wb_hartid_o   = wb_entry_reg.hartid;
    assign bus.wb_id_o       = wb_entry_reg.id;
    assign bus.wb_overflow_o = wb_entry_reg.overflow;
    assign bus.wb_lane_o     = wb_lane_reg;
    assign bus.drop_o        = drop_reg;
    assign bus.err_o         = err_reg;
    assign bus.idle_o        = !any_busy && !wb_valid_reg;

endmodule

// File: tb/tb_multi_issue_result_collector.sv
// Directed checks of the result collector with hand-computed expectations.
module tb_multi_issue_result_collector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    multi_issue_result_collector_if #(.ISSUE_WIDTH(4), .XLEN(32)) bus ();

    multi_issue_result_collector #(
        .ISSUE_WIDTH (4),
        .XLEN        (32),
        .FIFO_DEPTH  (4),
        .SKID        (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.result_valid_i    = '0;
        bus.result_i          = '0;
        bus.result_we_i       = '0;
        bus.result_rd_addr_i  = '0;
        bus.result_hartid_i   = '0;
        bus.result_id_i       = '0;
        bus.result_overflow_i = '0;
    endtask

    // Side fields are derived from the data so every field is exercised.
    task automatic drive(input int lane, input logic [31:0] d, input logic [4:0] rd);
        bus.result_valid_i[lane]    = 1'b1;
        bus.result_i[lane]          = d;
        bus.result_we_i[lane]       = 1'b1;
        bus.result_rd_addr_i[lane]  = rd;
        bus.result_hartid_i[lane]   = d[2];
        bus.result_id_i[lane]       = d[1];
        bus.result_overflow_i[lane] = d[0];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_wb(input string tag, input int lane, input logic [31:0] d,
                             input logic [4:0] rd);
        check({tag, ".valid"},    64'(bus.wb_valid_o),    64'd1);
        check({tag, ".data"},     64'(bus.wb_data_o),     64'(d));
        check({tag, ".rd"},       64'(bus.wb_rd_addr_o),  64'(rd));
        check({tag, ".lane"},     64'(bus.wb_lane_o),     64'(lane));
        check({tag, ".we"},       64'(bus.wb_we_o),       64'd1);
        check({tag, ".overflow"}, 64'(bus.wb_overflow_o), 64'(d[0]));
        check({tag, ".id"},       64'(bus.wb_id_o),       64'(d[1]));
        check({tag, ".hartid"},   64'(bus.wb_hartid_o),   64'(d[2]));
        $display("wb %s lane=%0d data=%08h rd=%0d", tag, bus.wb_lane_o, bus.wb_data_o,
                 bus.wb_rd_addr_o);
    endtask

    initial begin
        clear_inputs();
        bus.wb_ready_i = 1'b1;
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst.valid",      64'(bus.wb_valid_o),   64'd0);
        check("rst.idle",       64'(bus.idle_o),       64'd1);
        check("rst.lane_ready", 64'(bus.lane_ready_o), 64'hF);
        check("rst.err",        64'(bus.err_o),        64'd0);
        check("rst.drop",       64'(bus.drop_o),       64'd0);
        check("rst.data",       64'(bus.wb_data_o),    64'd0);
        check("rst.rd",         64'(bus.wb_rd_addr_o), 64'd0);
        check("rst.lane",       64'(bus.wb_lane_o),    64'd0);
        rst = 1'b0;

        // Single result on lane 2
        drive(2, 32'hDEADBEEF, 5'd5);
        tick();
        clear_inputs();
        check("t1.c1.valid", 64'(bus.wb_valid_o), 64'd0);
        check("t1.c1.idle",  64'(bus.idle_o),     64'd0);
        tick();
        expect_wb("t1.c2", 2, 32'hDEADBEEF, 5'd5);
        tick();
        check("t1.c3.valid", 64'(bus.wb_valid_o), 64'd0);
        check("t1.c3.idle",  64'(bus.idle_o),     64'd1);

        // All four lanes at once after a fresh reset: lane order 0..3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 32'h100 + 32'(i), 5'(10 + i));
        tick();
        clear_inputs();
        check("t2.c1.valid", 64'(bus.wb_valid_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_wb($sformatf("t2.c%0d", i + 2), i, 32'h100 + 32'(i), 5'(10 + i));
        end
        tick();
        check("t2.c6.valid", 64'(bus.wb_valid_o), 64'd0);

        // Back-pressure: lane 0 entry stalls in the output register, lane 1 fills
        bus.wb_ready_i = 1'b0;
        drive(0, 32'h55, 5'd1);
        tick();
        clear_inputs();
        drive(1, 32'hA0, 5'd2);
        tick();
        expect_wb("t3.c2", 0, 32'h55, 5'd1);
        clear_inputs();
        drive(1, 32'hA1, 5'd3);
        tick();
        check("t3.c3.lane_ready", 64'(bus.lane_ready_o), 64'hF);
        clear_inputs();
        drive(1, 32'hA2, 5'd4);
        tick();
        check("t3.c4.lane_ready", 64'(bus.lane_ready_o), 64'hD);
        clear_inputs();
        drive(1, 32'hA3, 5'd6);
        tick();
        clear_inputs();
        check("t3.c5.lane_ready", 64'(bus.lane_ready_o), 64'hD);
        check("t3.c5.err",        64'(bus.err_o),        64'd0);
        for (int i = 0; i < 5; i++) begin
            check("t3.stall.valid", 64'(bus.wb_valid_o), 64'd1);
            check("t3.stall.data",  64'(bus.wb_data_o),  64'h55);
            check("t3.stall.lane",  64'(bus.wb_lane_o),  64'd0);
            tick();
        end
        bus.wb_ready_i = 1'b1;
        tick();
        expect_wb("t3.c11", 1, 32'hA0, 5'd2);
        tick();
        expect_wb("t3.c12", 1, 32'hA1, 5'd3);
        check("t3.c12.lane_ready", 64'(bus.lane_ready_o), 64'hF);
        tick();
        expect_wb("t3.c13", 1, 32'hA2, 5'd4);
        tick();
        expect_wb("t3.c14", 1, 32'hA3, 5'd6);
        tick();
        check("t3.c15.valid", 64'(bus.wb_valid_o), 64'd0);
        check("t3.c15.idle",  64'(bus.idle_o),     64'd1);

        // Overflow on lane 0 while a lane 3 entry is stalled
        bus.wb_ready_i = 1'b0;
        drive(3, 32'hC3, 5'd3);
        tick();
        clear_inputs();
        drive(0, 32'hB0, 5'd8);
        tick();
        expect_wb("t4.c2", 3, 32'hC3, 5'd3);
        for (int i = 1; i <= 3; i++) begin
            clear_inputs();
            drive(0, 32'hB0 + 32'(i), 5'(8 + i));
            tick();
        end
        check("t4.c5.drop", 64'(bus.drop_o), 64'd0);
        clear_inputs();
        drive(0, 32'hB4, 5'd12);
        tick();
        check("t4.c6.drop", 64'(bus.drop_o), 64'd1);
        check("t4.c6.err",  64'(bus.err_o),  64'd1);
        clear_inputs();
        drive(0, 32'hB5, 5'd13);
        tick();
        check("t4.c7.drop", 64'(bus.drop_o), 64'd1);
        clear_inputs();
        tick();
        check("t4.c8.drop", 64'(bus.drop_o), 64'd0);
        check("t4.c8.err",  64'(bus.err_o),  64'd1);
        bus.wb_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_wb($sformatf("t4.c%0d", i + 9), 0, 32'hB0 + 32'(i), 5'(8 + i));
        end
        tick();
        check("t4.c13.valid", 64'(bus.wb_valid_o), 64'd0);
        check("t4.c13.idle",  64'(bus.idle_o),     64'd1);
        check("t4.c13.err",   64'(bus.err_o),      64'd1);

        // Lane 3 full, popped and pushed in the same cycle
        bus.wb_ready_i = 1'b0;
        drive(3, 32'hD0, 5'd16);
        tick();
        clear_inputs();
        drive(3, 32'hD1, 5'd17);
        tick();
        expect_wb("t5.c2", 3, 32'hD0, 5'd16);
        for (int i = 2; i <= 4; i++) begin
            clear_inputs();
            drive(3, 32'hD0 + 32'(i), 5'(16 + i));
            tick();
        end
        check("t5.c5.lane_ready", 64'(bus.lane_ready_o), 64'h7);
        bus.wb_ready_i = 1'b1;
        clear_inputs();
        drive(3, 32'hD5, 5'd21);
        tick();
        clear_inputs();
        check("t5.c6.drop",       64'(bus.drop_o),       64'd0);
        check("t5.c6.lane_ready", 64'(bus.lane_ready_o), 64'h7);
        expect_wb("t5.c6", 3, 32'hD1, 5'd17);
        tick();
        expect_wb("t5.c7", 3, 32'hD2, 5'd18);
        check("t5.c7.lane_ready", 64'(bus.lane_ready_o), 64'h7);
        tick();
        expect_wb("t5.c8", 3, 32'hD3, 5'd19);
        check("t5.c8.lane_ready", 64'(bus.lane_ready_o), 64'hF);
        tick();
        expect_wb("t5.c9", 3, 32'hD4, 5'd20);
        tick();
        expect_wb("t5.c10", 3, 32'hD5, 5'd21);
        tick();
        check("t5.c11.valid", 64'(bus.wb_valid_o), 64'd0);
        check("t5.c11.idle",  64'(bus.idle_o),     64'd1);

        // Reset mid-stream with buffered entries and a presented entry
        bus.wb_ready_i = 1'b0;
        drive(1, 32'hE1, 5'd1);
        drive(2, 32'hE2, 5'd2);
        drive(3, 32'hE3, 5'd3);
        tick();
        clear_inputs();
        drive(2, 32'hE4, 5'd4);
        tick();
        clear_inputs();
        check("t6.c2.valid", 64'(bus.wb_valid_o), 64'd1);
        check("t6.c2.lane",  64'(bus.wb_lane_o),  64'd1);
        check("t6.c2.idle",  64'(bus.idle_o),     64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t6.rst.valid",      64'(bus.wb_valid_o),   64'd0);
        check("t6.rst.idle",       64'(bus.idle_o),       64'd1);
        check("t6.rst.lane_ready", 64'(bus.lane_ready_o), 64'hF);
        check("t6.rst.err",        64'(bus.err_o),        64'd0);
        check("t6.rst.data",       64'(bus.wb_data_o),    64'd0);
        tick();
        rst = 1'b0;
        bus.wb_ready_i = 1'b1;
        drive(0, 32'hF0, 5'd7);
        drive(3, 32'hF3, 5'd9);
        tick();
        clear_inputs();
        check("t6.c1.valid", 64'(bus.wb_valid_o), 64'd0);
        tick();
        expect_wb("t6.c2", 0, 32'hF0, 5'd7);
        tick();
        expect_wb("t6.c3", 3, 32'hF3, 5'd9);
        tick();
        check("t6.c4.valid", 64'(bus.wb_valid_o), 64'd0);
        check("t6.c4.idle",  64'(bus.idle_o),     64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_issue_result_collector.md
# multi_issue_result_collector

Downstream of the multi-issue execution unit. Accepts up to ISSUE_WIDTH completed results per cycle, buffers them in per-lane FIFOs, and serialises them onto one valid/ready writeback port using round-robin arbitration. It feeds the single-result writeback interface back to the core and returns per-lane back-pressure to the issue stage.

## Interface
Parameters:
- ISSUE_WIDTH, 4: number of execution lanes (2–8).
- XLEN, 32: result width.
- FIFO_DEPTH, 4: entries per lane FIFO; power of two, at least 2.
- SKID, 2: free entries required for lane_ready_o; must satisfy 1 ≤ SKID ≤ FIFO_DEPTH.
- hartid_t, logic: hart ID type.
- id_t, logic: instruction ID type.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- result_valid_i  in  ISSUE_WIDTH  per-lane result strobe.
- result_i  in  ISSUE_WIDTH×XLEN  per-lane result data.
- result_we_i  in  ISSUE_WIDTH  per-lane register write enable.
- result_rd_addr_i  in  ISSUE_WIDTH×5  per-lane destination register.
- result_hartid_i  in  hartid_t[ISSUE_WIDTH]  per-lane hart ID.
- result_id_i  in  id_t[ISSUE_WIDTH]  per-lane instruction ID.
- result_overflow_i  in  ISSUE_WIDTH  per-lane overflow flag.
- lane_ready_o  out  ISSUE_WIDTH  lane may issue; its FIFO has at least SKID free entries.
- wb_valid_o  out  1  writeback entry valid.
- wb_ready_i  in  1  writeback sink accepts the entry.
- wb_data_o  out  XLEN  result data.
- wb_we_o  out  1  write enable.
- wb_rd_addr_o  out  5  destination register.
- wb_hartid_o  out  hartid_t  hart ID.
- wb_id_o  out  id_t  instruction ID.
- wb_overflow_o  out  1  overflow flag.
- wb_lane_o  out  $clog2(ISSUE_WIDTH)  lane the entry came from.
- drop_o  out  ISSUE_WIDTH  one-cycle pulse when a result arrives at a full FIFO and is lost.
- err_o  out  1  sticky drop flag; cleared only by reset.
- idle_o  out  1  all FIFOs and the output register are empty.

## Operation
- Each lane has a FIFO of {data, we, rd_addr, hartid, id, overflow}. The FIFO pushes whenever result_valid_i[i] is high.
- A full FIFO accepts a push only if it is popped in the same cycle; its count is unchanged. Otherwise the result is discarded, drop_o[i] pulses, and err_o sets.
- Empty FIFO with push and no pop: count becomes 1. Read and write pointers wrap modulo FIFO_DEPTH.
- lane_ready_o[i] = (FIFO_DEPTH − count[i]) ≥ SKID. It is registered from the count, so it reflects post-edge occupancy.
- Output register load condition: (!wb_valid_o || wb_ready_i) and at least one FIFO is non-empty.
- Arbiter: round-robin. Search starts at lane last_grant+1 and wraps modulo ISSUE_WIDTH. The first non-empty lane is popped into the output register, and last_grant updates only on a load.
- If the load condition is false, nothing is popped and last_grant holds.
- While wb_valid_o && !wb_ready_i, all wb_* outputs stay stable.
- Entries from one lane leave in arrival order. Cross-lane order is determined only by round-robin.
- idle_o = all counts are 0 && !wb_valid_o.
- Reset values (asynchronous): every FIFO count and pointer is 0; last_grant = ISSUE_WIDTH−1, so lane 0 has first priority; wb_valid_o = 0; wb_* data outputs = 0; drop_o = 0; err_o = 0; lane_ready_o = all ones; idle_o = 1.
- Reset asserted mid-operation discards every buffered and presented entry immediately.

## Timing
- Latency: a result presented in cycle N is written at edge N. It can load into the output register at edge N+1, so wb_valid_o is high in cycle N+2 at the earliest.
- Throughput: one writeback per cycle while wb_ready_i stays high.
- lane_ready_o changes one cycle after the push or pop that crosses the SKID threshold.
- drop_o is asserted in the cycle after the lost push (registered).

## Structure
- Shared package multi_issue_pkg holds:
  - the lane-index width helper function;
  - the default constants DEFAULT_FIFO_DEPTH and DEFAULT_SKID.
- The entry struct is declared locally, because it depends on the type parameters.
- Sub-module result_lane_fifo: parameterised depth and entry type, with push/pop/full/empty/count. It is instantiated ISSUE_WIDTH times in a generate loop.
- The arbiter and output register are in the top module.

## Test plan
- Single result: lane 2 in cycle 0 with data 0xDEADBEEF, rd 5, wb_ready_i=1 → wb_valid_o in cycle 2 with data 0xDEADBEEF, rd 5, lane 2; idle_o returns to 1 in cycle 3.
- All four lanes valid in cycle 0 with ready held high → four writebacks in cycles 2–5, in lane order 0,1,2,3.
- Back-pressure: wb_ready_i=0 for 10 cycles while lane 1 pushes 4 results → lane_ready_o[1] drops after the 3rd push. When ready rises, the results drain in push order and wb_* is stable while stalled.
- Overflow: lane 0 pushes 6 results with ready low → 5th and 6th push each produce a drop_o[0] pulse; err_o=1 and stays set; exactly 4 results drain.
- Full FIFO with simultaneous push and pop: lane 3 full, arbiter pops lane 3 and a push arrives in the same cycle → no drop, count stays 4.
- Reset mid-stream: assert rst_i with 3 entries buffered and wb_valid_o=1 → wb_valid_o=0 and idle_o=1 immediately; the next result is emitted from lane 0 priority.
